spi_slave_frame: RTL and testbench

Parametrised SPI slave front-end operating entirely in the SCLK domain, the successor to the fixed 8-bit, mode-0 slave. It supports configurable word width, CPHA mode and bit order, and multi-word bursts within one SS-low frame. Per-word receive strobes, transmit-load indication, a word counter and a partial-word error flag are provided to the protocol layer above it.

---
 rtl/spi_slave_frame_if.sv | 23 ++
 rtl/spi_slave_frame.sv | 132 +++++++++++++
 tb/tb_spi_slave_frame.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_frame_if.sv
// Parallel-side bus between the SPI slave front-end and the protocol layer above it.
// The slave modport is the front-end; the master modport is the protocol layer.
interface spi_slave_frame_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 4
) ();
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_load;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic [CNT_WIDTH-1:0]  word_cnt;
   logic                  frame_err;

   modport slave (
      input  tx_data,
      output tx_load, rx_data, rx_valid, word_cnt, frame_err
   );

   modport master (
      output tx_data,
      input  tx_load, rx_data, rx_valid, word_cnt, frame_err
   );
endinterface

// File: rtl/spi_slave_frame.sv
// SCLK-domain SPI slave with configurable width, CPHA and bit order; supports
// back-to-back words within one SS-low frame and flags frames ending mid-word.
module spi_slave_frame #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CPHA       = 0,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned CNT_WIDTH  = 4
) (
   input  logic SCLK,
   input  logic reset,
   input  logic SS,
   input  logic MOSI,
   output wire  MISO,
   spi_slave_frame_if.slave bus
);
   localparam int unsigned BitW = $clog2(DATA_WIDTH);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

   logic                  cap_clk;
   logic                  frame_rst_n;
   logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_word;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic                  started_q;
   logic                  mid_word_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  miso_bit;

   function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
   endfunction

   // Capture edge is the rising SCLK edge for CPHA=0, falling for CPHA=1.
   assign cap_clk     = (CPHA != 0) ? ~SCLK : SCLK;
   assign frame_rst_n = reset & ~SS;

   always_comb begin
      word_done = (bit_cnt_q == LastBit);
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BitW'(1);
      rx_word   = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], MOSI}
                                   : {MOSI, rx_shift_q[DATA_WIDTH-1:1]};
      word_cnt_d = started_q ? word_cnt_q : '0;
      if (word_done && (word_cnt_d != '1)) begin
         word_cnt_d = word_cnt_d + CNT_WIDTH'(1);
      end
   end

   // Per-frame state, wiped whenever SS is high.
   always_ff @(posedge cap_clk or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         started_q  <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_word;
         started_q  <= 1'b1;
      end
   end

   // Results that survive SS high for readout.
   always_ff @(posedge cap_clk or negedge reset) begin
      if (!reset) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         word_cnt_q <= '0;
         mid_word_q <= 1'b0;
      end else if (!SS) begin
         mid_word_q <= (bit_cnt_d != '0);
         word_cnt_q <= word_cnt_d;
         if (word_done) begin
            rx_data_q  <= rx_word;
            rx_valid_q <= 1'b1;
         end else if (bit_cnt_q == '0) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   // mid_word_q is not cleared by SS, so it still holds the word position here.
   always_ff @(posedge SS or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= mid_word_q;
      end
   end

   always_comb begin
      tx_shift_d = shift_out(tx_shift_q);
      if (CPHA == 0) begin
         if (bit_cnt_q == BitW'(1)) begin
            tx_shift_d = shift_out(bus.tx_data);
         end
      end else begin
         if (bit_cnt_q == '0) begin
            tx_shift_d = bus.tx_data;
         end
      end
   end

   always_ff @(negedge cap_clk or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         tx_shift_q <= '0;
      end else begin
         tx_shift_q <= tx_shift_d;
      end
   end

   always_comb begin
      if ((CPHA == 0) && (bit_cnt_q == '0)) begin
         miso_bit = lead_bit(bus.tx_data);
      end else begin
         miso_bit = lead_bit(tx_shift_q);
      end
   end

   assign MISO          = SS ? 1'bz : miso_bit;
   assign bus.tx_load   = reset & ~SS & (bit_cnt_q == '0);
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.word_cnt  = word_cnt_q;
   assign bus.frame_err = err_q & ~started_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: mode 0 / MSB-first W=8, mode 1 / LSB-first W=12,
// and a CNT_WIDTH=2 instance for word-counter saturation.
module tb_spi_slave_frame;
   logic sclk_a, ss_a, mosi_a;
   logic sclk_b, ss_b, mosi_b;
   logic rst_n;
   wire  miso0, miso1, miso2;

   // Pull-ups make an undriven (high-Z) MISO read back as 1.
   pullup (miso0);
   pullup (miso1);
   pullup (miso2);

   spi_slave_frame_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4)) bus0 ();
   spi_slave_frame_if #(.DATA_WIDTH(12), .CNT_WIDTH(4)) bus1 ();
   spi_slave_frame_if #(.DATA_WIDTH(8),  .CNT_WIDTH(2)) bus2 ();

   spi_slave_frame #(.DATA_WIDTH(8), .CPHA(0), .MSB_FIRST(1), .CNT_WIDTH(4)) u0 (
      .SCLK(sclk_a), .reset(rst_n), .SS(ss_a), .MOSI(mosi_a), .MISO(miso0), .bus(bus0)
   );
   spi_slave_frame #(.DATA_WIDTH(12), .CPHA(1), .MSB_FIRST(0), .CNT_WIDTH(4)) u1 (
      .SCLK(sclk_b), .reset(rst_n), .SS(ss_b), .MOSI(mosi_b), .MISO(miso1), .bus(bus1)
   );
   spi_slave_frame #(.DATA_WIDTH(8), .CPHA(0), .MSB_FIRST(1), .CNT_WIDTH(2)) u2 (
      .SCLK(sclk_a), .reset(rst_n), .SS(ss_a), .MOSI(mosi_a), .MISO(miso2), .bus(bus2)
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic [7:0] mo;
      logic [7:0] tx;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vecs[4];
   int   checks;
   int   errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Mode 0 master: n bits MSB first; samples MISO just before each rising edge.
   // Leaves SCLK high after the last rising edge.
   task automatic spi0_bits(input logic [7:0] mo, input logic [7:0] tx, input int n,
                            output logic [7:0] mi);
      mi = '0;
      bus0.tx_data = tx;
      bus2.tx_data = tx;
      #1;
      sclk_a = 1'b0;
      for (int i = 7; i >= 8 - n; i--) begin
         mosi_a = mo[i];
         #4;
         mi[i]  = miso0;
         sclk_a = 1'b1;
         #5;
         if (i != 8 - n) begin
            sclk_a = 1'b0;
         end
      end
   endtask

   task automatic ss_a_start();
      sclk_a = 1'b0;
      #5;
      ss_a = 1'b0;
      #5;
   endtask

   task automatic ss_a_end();
      sclk_a = 1'b0;
      #5;
      ss_a = 1'b1;
      #5;
   endtask

   initial begin
      logic [7:0]  mi;
      logic [11:0] mi12;
      logic [7:0]  burst_mo[5];
      logic [1:0]  burst_cnt[5];

      checks = 0;
      errors = 0;
      sclk_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0;
      sclk_b = 1'b0; ss_b = 1'b1; mosi_b = 1'b0;
      bus0.tx_data = 8'h00;
      bus1.tx_data = 12'h000;
      bus2.tx_data = 8'h00;
      rst_n = 1'b0;

      vecs[0] = '{start: 1'b1, stop: 1'b1, mo: 8'hA5, tx: 8'h3C,
                  exp_rx: 8'hA5, exp_miso: 8'h3C, exp_cnt: 4'd1};
      vecs[1] = '{start: 1'b1, stop: 1'b0, mo: 8'h11, tx: 8'h81,
                  exp_rx: 8'h11, exp_miso: 8'h81, exp_cnt: 4'd1};
      vecs[2] = '{start: 1'b0, stop: 1'b0, mo: 8'h22, tx: 8'h42,
                  exp_rx: 8'h22, exp_miso: 8'h42, exp_cnt: 4'd2};
      vecs[3] = '{start: 1'b0, stop: 1'b1, mo: 8'h33, tx: 8'h24,
                  exp_rx: 8'h33, exp_miso: 8'h24, exp_cnt: 4'd3};

      // Reset state
      #10;
      chk("rst_rx_data", 32'(bus0.rx_data), 32'h0);
      chk("rst_rx_valid", 32'(bus0.rx_valid), 32'h0);
      chk("rst_word_cnt", 32'(bus0.word_cnt), 32'h0);
      chk("rst_frame_err", 32'(bus0.frame_err), 32'h0);
      chk("rst_tx_load", 32'(bus0.tx_load), 32'h0);
      chk("rst_miso_hiz", 32'(miso0), 32'h1);
      chk("rst_rx_data_w12", 32'(bus1.rx_data), 32'h0);
      rst_n = 1'b1;
      #10;

      // Single word then 3-word burst
      foreach (vecs[k]) begin
         if (vecs[k].start) begin
            ss_a_start();
         end
         spi0_bits(vecs[k].mo, vecs[k].tx, 8, mi);
         chk($sformatf("v%0d_rx_data", k), 32'(bus0.rx_data), 32'(vecs[k].exp_rx));
         chk($sformatf("v%0d_rx_valid", k), 32'(bus0.rx_valid), 32'h1);
         chk($sformatf("v%0d_word_cnt", k), 32'(bus0.word_cnt), 32'(vecs[k].exp_cnt));
         chk($sformatf("v%0d_miso", k), 32'(mi), 32'(vecs[k].exp_miso));
         chk($sformatf("v%0d_tx_load", k), 32'(bus0.tx_load), 32'h1);
         chk($sformatf("v%0d_frame_err", k), 32'(bus0.frame_err), 32'h0);
         if (vecs[k].stop) begin
            ss_a_end();
            chk($sformatf("v%0d_ss_hi_err", k), 32'(bus0.frame_err), 32'h0);
         end
      end

      // Frame aborted after 5 bits
      ss_a_start();
      spi0_bits(8'hF8, 8'h00, 5, mi);
      ss_a_end();
      chk("abort_frame_err", 32'(bus0.frame_err), 32'h1);
      chk("abort_rx_data", 32'(bus0.rx_data), 32'h33);
      chk("abort_rx_valid", 32'(bus0.rx_valid), 32'h0);
      chk("abort_word_cnt", 32'(bus0.word_cnt), 32'h0);
      chk("abort_miso_hiz", 32'(miso0), 32'h1);
      chk("abort_tx_load", 32'(bus0.tx_load), 32'h0);
      ss_a = 1'b0;
      #5;
      chk("err_held_before_cap", 32'(bus0.frame_err), 32'h1);

      // Next frame clears the error on its first capture; reset hits after bit 3
      spi0_bits(8'hF0, 8'h00, 4, mi);
      chk("err_cleared", 32'(bus0.frame_err), 32'h0);
      rst_n = 1'b0;
      #2;
      chk("midrst_rx_valid", 32'(bus0.rx_valid), 32'h0);
      chk("midrst_rx_data", 32'(bus0.rx_data), 32'h0);
      chk("midrst_word_cnt", 32'(bus0.word_cnt), 32'h0);
      chk("midrst_tx_load", 32'(bus0.tx_load), 32'h0);
      chk("midrst_miso_driven", 32'(miso0), 32'h0);
      rst_n = 1'b1;
      #3;
      ss_a_end();
      chk("postrst_frame_err", 32'(bus0.frame_err), 32'h0);
      ss_a_start();
      spi0_bits(8'h5A, 8'hC3, 8, mi);
      chk("postrst_rx_data", 32'(bus0.rx_data), 32'h5A);
      chk("postrst_word_cnt", 32'(bus0.word_cnt), 32'h1);
      chk("postrst_miso", 32'(mi), 32'hC3);
      ss_a_end();

      // CNT_WIDTH=2 saturation over a 5-word burst
      burst_mo  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
      burst_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      ss_a_start();
      for (int k = 0; k < 5; k++) begin
         spi0_bits(burst_mo[k], 8'h00, 8, mi);
         chk($sformatf("sat%0d_word_cnt", k), 32'(bus2.word_cnt), 32'(burst_cnt[k]));
         chk($sformatf("sat%0d_rx_data", k), 32'(bus2.rx_data), 32'(burst_mo[k]));
      end
      ss_a_end();
      chk("sat_ss_hi_miso_hiz", 32'(miso2), 32'h1);

      // CPHA=1, LSB first, W=12: master launches on rise, samples MISO before fall
      bus1.tx_data = 12'h5A3;
      mi12 = '0;
      ss_b = 1'b0;
      #5;
      for (int i = 0; i < 12; i++) begin
         sclk_b = 1'b1;
         mosi_b = 1'((12'hABC >> i) & 12'h1);
         #4;
         mi12[i] = miso1;
         #1;
         sclk_b = 1'b0;
         #5;
      end
      chk("m1_rx_data", 32'(bus1.rx_data), 32'hABC);
      chk("m1_rx_valid", 32'(bus1.rx_valid), 32'h1);
      chk("m1_word_cnt", 32'(bus1.word_cnt), 32'h1);
      chk("m1_miso", 32'(mi12), 32'h5A3);
      chk("m1_tx_load", 32'(bus1.tx_load), 32'h1);
      ss_b = 1'b1;
      #5;
      chk("m1_frame_err", 32'(bus1.frame_err), 32'h0);
      chk("m1_miso_hiz", 32'(miso1), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
